fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage feeding the IF/ID pipeline register. It sits directly upstream of decode and consumes the load-use `stall` produced by hazard detection.
- Owns the PC and the request/response handshake to the instruction cache. Allows one outstanding request.
- Holds IF/ID contents while stalled, buffers one returned instruction, and kills in-flight fetches on a branch/jump redirect.
- Sustains 1 instruction/cycle with a 1-cycle-latency cache.

Parameters:
- PC_W, 32, PC/address width
- INSTR_W, 32, instruction width
- RESET_PC, 32'h0000_0000, first fetch address after reset
- NOP_INSTR, 32'h0000_0000, instruction value presented when IF/ID is invalid

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- stall_i  in  1  load-use stall from hazard control; hold PC and IF/ID
- redirect_valid  in  1  taken branch/jump resolved downstream
- redirect_pc  in  PC_W  redirect target
- ic_req_valid  out  1  cache request valid
- ic_req_ready  in  1  cache accepts request
- ic_req_addr  out  PC_W  fetch address
- ic_resp_valid  in  1  cache returns instruction (in order, ≥1 cycle after accept)
- ic_resp_instr  in  INSTR_W  returned instruction
- if_id_valid  out  1  IF/ID holds a real instruction
- if_id_pc  out  PC_W  PC of that instruction
- if_id_instr  out  INSTR_W  instruction (NOP_INSTR when invalid)

Behaviour:
- Internal registers:
  - pc: next address to request
  - pc_req: address of the outstanding request
  - kill: drop the next response
  - hold_buf/hold_pc: one-entry buffer
  - state
- Reset (async, rst_n=0):
  - state=BOOT, pc=RESET_PC, pc_req=0, kill=0
  - if_id_valid=0, if_id_pc=0, if_id_instr=NOP_INSTR
  - ic_req_valid=0
  - BOOT moves to REQ on the first clock edge after release.
- ic_req_addr = pc at all times.
- Request acceptance: accepted when ic_req_valid && ic_req_ready. On accept: pc_req<=pc, pc<=pc+4 (mod 2^PC_W).
- States:
  - BOOT:
    - ic_req_valid=0.
  - REQ:
    - ic_req_valid=1.
    - Accept -> WAIT. No accept -> stay.
    - redirect_valid without accept: pc<=redirect_pc, stay.
    - redirect_valid with accept: pc<=redirect_pc, kill<=1, -> WAIT.
  - WAIT:
    - ic_req_valid = ic_resp_valid && !stall_i && !redirect_valid. This is the only combinational input->output path.
    - Response with kill=1: drop it, kill<=0. If the new request is accepted, stay WAIT; else -> REQ.
    - Response, kill=0, stall_i=0, no redirect: load IF/ID {1, pc_req, instr}. If the new request is accepted, stay WAIT; else -> REQ.
    - Response, kill=0, stall_i=1, no redirect: hold_buf<=instr, hold_pc<=pc_req, -> HOLD.
    - redirect_valid without response: pc<=redirect_pc, kill<=1, stay WAIT.
    - redirect_valid with response: drop the response, pc<=redirect_pc, -> REQ.
  - HOLD:
    - ic_req_valid=0.
    - stall_i=0: IF/ID<={1, hold_pc, hold_buf}, -> REQ.
    - redirect_valid: discard the buffer, pc<=redirect_pc, -> REQ.
- IF/ID update priority each cycle:
  1. redirect_valid -> if_id_valid<=0, if_id_instr<=NOP_INSTR. Redirect overrides stall.
  2. stall_i -> hold all IF/ID fields.
  3. New instruction delivered -> load it.
  4. Otherwise -> bubble (valid<=0, instr<=NOP_INSTR, pc unchanged).
- kill is never set while already set: at most one outstanding request.
- Reset mid-operation: all state is discarded. Any cache response arriving in BOOT is ignored.

Decomposition:
- Shared define.v gets: `PC_W, `INSTR_W, `RESET_PC, `NOP_INSTR, and state encodings `FS_BOOT/`FS_REQ/`FS_WAIT/`FS_HOLD (2 bits).
- One natural sub-module: if_id_reg. It is the IF/ID pipeline register with stall-hold, flush and bubble priority as above, and is reusable for later pipeline registers.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles, then release.
  -> ic_req_valid=0 during reset and for 1 cycle after; first request addr=RESET_PC; if_id_valid=0.
- Straight line: 1-cycle cache, ready=1, instrs 0x11,0x22,0x33.
  -> IF/ID shows PC 0x0,0x4,0x8 on consecutive cycles, 1/cycle, valid=1.
- Stall during response: stall_i=1 in the cycle instr 0x22 returns, for 2 cycles.
  -> IF/ID holds PC 0x0/0x11; after release, IF/ID=PC 0x4/0x22, no instruction lost or duplicated.
- Redirect while outstanding: redirect_valid with redirect_pc=0x100 while in WAIT; stale response arrives next cycle.
  -> stale instr dropped, if_id_valid=0; next request addr=0x100; IF/ID later shows PC 0x100.
- Redirect+stall same cycle.
  -> if_id_valid<=0 (redirect wins); HOLD buffer discarded; fetch resumes at redirect_pc.
- Backpressure/wrap: ic_req_ready=0 for 3 cycles at pc=0xFFFF_FFFC.
  -> addr stable at 0xFFFF_FFFC; after accept, next addr=0x0000_0000.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared constants for the instruction-fetch stage: default widths and the
// fetch FSM state encodings.
package fetch_stage_pkg;

    localparam int PC_W_DEF    = 32;
    localparam int INSTR_W_DEF = 32;

    localparam logic [1:0] FS_BOOT = 2'd0;
    localparam logic [1:0] FS_REQ  = 2'd1;
    localparam logic [1:0] FS_WAIT = 2'd2;
    localparam logic [1:0] FS_HOLD = 2'd3;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush beats stall, stall holds everything,
// otherwise load a delivered instruction or insert a bubble.
module if_id_reg #(
    parameter int                 PC_W      = 32,
    parameter int                 INSTR_W   = 32,
    parameter logic [INSTR_W-1:0] NOP_INSTR = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               stall,
    input  logic               load_valid,
    input  logic [PC_W-1:0]    load_pc,
    input  logic [INSTR_W-1:0] load_instr,
    output logic               valid,
    output logic [PC_W-1:0]    pc,
    output logic [INSTR_W-1:0] instr
);

    logic               valid_reg;
    logic [PC_W-1:0]    pc_reg;
    logic [INSTR_W-1:0] instr_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= 1'b0;
            pc_reg    <= '0;
            instr_reg <= NOP_INSTR;
        end else if (flush) begin
            valid_reg <= 1'b0;
            instr_reg <= NOP_INSTR;
        end else if (stall) begin
            valid_reg <= valid_reg;
        end else if (load_valid) begin
            valid_reg <= 1'b1;
            pc_reg    <= load_pc;
            instr_reg <= load_instr;
        end else begin
            // Bubble keeps the last PC so debug views stay meaningful.
            valid_reg <= 1'b0;
            instr_reg <= NOP_INSTR;
        end
    end

    assign valid = valid_reg;
    assign pc    = pc_reg;
    assign instr = instr_reg;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives a single-outstanding-request
// cache handshake, buffers one response under stall and kills stale fetches.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int                 PC_W      = PC_W_DEF,
    parameter int                 INSTR_W   = INSTR_W_DEF,
    parameter logic [PC_W-1:0]    RESET_PC  = '0,
    parameter logic [INSTR_W-1:0] NOP_INSTR = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall_i,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               ic_req_valid,
    input  logic               ic_req_ready,
    output logic [PC_W-1:0]    ic_req_addr,
    input  logic               ic_resp_valid,
    input  logic [INSTR_W-1:0] ic_resp_instr,
    output logic               if_id_valid,
    output logic [PC_W-1:0]    if_id_pc,
    output logic [INSTR_W-1:0] if_id_instr
);

    localparam logic [PC_W-1:0] PC_STEP = PC_W'(4);

    logic [1:0]         state_reg, state_next;
    logic [PC_W-1:0]    pc_reg, pc_next;
    logic [PC_W-1:0]    pc_req_reg, pc_req_next;
    logic               kill_reg, kill_next;
    logic [INSTR_W-1:0] hold_buf_reg, hold_buf_next;
    logic [PC_W-1:0]    hold_pc_reg, hold_pc_next;

    logic               req_valid;
    logic               accept;
    logic               deliver_valid;
    logic [PC_W-1:0]    deliver_pc;
    logic [INSTR_W-1:0] deliver_instr;

    // In WAIT the next request is issued back-to-back with the response,
    // which is what sustains one instruction per cycle.
    always_comb begin
        req_valid = 1'b0;
        case (state_reg)
            FS_REQ:  req_valid = 1'b1;
            FS_WAIT: req_valid = ic_resp_valid && !stall_i && !redirect_valid;
            default: req_valid = 1'b0;
        endcase
    end

    assign accept       = req_valid && ic_req_ready;
    assign ic_req_valid = req_valid;
    assign ic_req_addr  = pc_reg;

    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        pc_req_next   = pc_req_reg;
        kill_next     = kill_reg;
        hold_buf_next = hold_buf_reg;
        hold_pc_next  = hold_pc_reg;
        deliver_valid = 1'b0;
        deliver_pc    = pc_req_reg;
        deliver_instr = ic_resp_instr;

        if (accept) begin
            pc_req_next = pc_reg;
            pc_next     = pc_reg + PC_STEP;
        end

        case (state_reg)
            FS_BOOT: state_next = FS_REQ;
            FS_REQ: begin
                if (redirect_valid) begin
                    pc_next = redirect_pc;
                    if (accept) kill_next = 1'b1;
                end
                if (accept) state_next = FS_WAIT;
            end
            FS_WAIT: begin
                if (ic_resp_valid) begin
                    kill_next = 1'b0;
                    if (redirect_valid) begin
                        pc_next    = redirect_pc;
                        state_next = FS_REQ;
                    end else if (kill_reg) begin
                        state_next = accept ? FS_WAIT : FS_REQ;
                    end else if (stall_i) begin
                        hold_buf_next = ic_resp_instr;
                        hold_pc_next  = pc_req_reg;
                        state_next    = FS_HOLD;
                    end else begin
                        deliver_valid = 1'b1;
                        state_next    = accept ? FS_WAIT : FS_REQ;
                    end
                end else if (redirect_valid) begin
                    pc_next   = redirect_pc;
                    kill_next = 1'b1;
                end
            end
            FS_HOLD: begin
                if (redirect_valid) begin
                    pc_next    = redirect_pc;
                    state_next = FS_REQ;
                end else if (!stall_i) begin
                    deliver_valid = 1'b1;
                    deliver_pc    = hold_pc_reg;
                    deliver_instr = hold_buf_reg;
                    state_next    = FS_REQ;
                end
            end
            default: state_next = FS_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= FS_BOOT;
            pc_reg       <= RESET_PC;
            pc_req_reg   <= '0;
            kill_reg     <= 1'b0;
            hold_buf_reg <= NOP_INSTR;
            hold_pc_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            pc_req_reg   <= pc_req_next;
            kill_reg     <= kill_next;
            hold_buf_reg <= hold_buf_next;
            hold_pc_reg  <= hold_pc_next;
        end
    end

    if_id_reg #(
        .PC_W      (PC_W),
        .INSTR_W   (INSTR_W),
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (redirect_valid),
        .stall      (stall_i),
        .load_valid (deliver_valid),
        .load_pc    (deliver_pc),
        .load_instr (deliver_instr),
        .valid      (if_id_valid),
        .pc         (if_id_pc),
        .instr      (if_id_instr)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: drives the cache side by hand each cycle
// and checks request and IF/ID outputs against hand-computed values.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall_i = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        ic_req_valid;
    logic        ic_req_ready = 1'b1;
    logic [31:0] ic_req_addr;
    logic        ic_resp_valid = 1'b0;
    logic [31:0] ic_resp_instr = '0;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall_i        (stall_i),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ic_req_valid   (ic_req_valid),
        .ic_req_ready   (ic_req_ready),
        .ic_req_addr    (ic_req_addr),
        .ic_resp_valid  (ic_resp_valid),
        .ic_resp_instr  (ic_resp_instr),
        .if_id_valid    (if_id_valid),
        .if_id_pc       (if_id_pc),
        .if_id_instr    (if_id_instr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("check %-16s observed %h expected %h", tag, obs, exp);
    endtask

    task automatic drive(input logic st, input logic rv, input logic [31:0] rpc,
                         input logic rdy, input logic rsp, input logic [31:0] ins);
        stall_i        = st;
        redirect_valid = rv;
        redirect_pc    = rpc;
        ic_req_ready   = rdy;
        ic_resp_valid  = rsp;
        ic_resp_instr  = ins;
    endtask

    task automatic check_ifid(input string tag, input logic v, input logic [31:0] p,
                              input logic [31:0] i);
        check({tag, ".v"}, 32'(if_id_valid), 32'(v));
        check({tag, ".pc"}, if_id_pc, p);
        check({tag, ".in"}, if_id_instr, i);
    endtask

    initial begin
        // Reset for three cycles
        drive(0, 0, 0, 1, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_v", 32'(ic_req_valid), 0);
        check_ifid("rst_ifid", 0, 32'h0, 32'h0);
        rst_n = 1'b1;
        #1 check("boot_req_v", 32'(ic_req_valid), 0);
        @(negedge clk);
        check("first_req_v", 32'(ic_req_valid), 1);
        check("first_addr", ic_req_addr, 32'h0);
        check("first_ifid_v", 32'(if_id_valid), 0);

        // Straight-line fetch at one instruction per cycle
        @(negedge clk);
        drive(0, 0, 0, 1, 1, 32'h11);
        #1 check("sl_req_v", 32'(ic_req_valid), 1);
        check("sl_addr4", ic_req_addr, 32'h4);
        @(negedge clk);
        check_ifid("sl_0", 1, 32'h0, 32'h11);
        drive(0, 0, 0, 1, 1, 32'h22);
        #1 check("sl_addr8", ic_req_addr, 32'h8);
        @(negedge clk);
        check_ifid("sl_4", 1, 32'h4, 32'h22);
        drive(0, 0, 0, 1, 1, 32'h33);
        @(negedge clk);
        check_ifid("sl_8", 1, 32'h8, 32'h33);

        // Stall in the cycle a response returns
        drive(1, 0, 0, 1, 1, 32'h44);
        #1 check("st_req_v", 32'(ic_req_valid), 0);
        @(negedge clk);
        check_ifid("st_hold1", 1, 32'h8, 32'h33);
        drive(1, 0, 0, 1, 0, 0);
        #1 check("hold_req_v", 32'(ic_req_valid), 0);
        @(negedge clk);
        check_ifid("st_hold2", 1, 32'h8, 32'h33);
        drive(0, 0, 0, 1, 0, 0);
        @(negedge clk);
        check_ifid("st_rel", 1, 32'hC, 32'h44);
        check("st_req_v2", 32'(ic_req_valid), 1);
        check("st_addr10", ic_req_addr, 32'h10);
        @(negedge clk);
        check_ifid("bubble", 0, 32'hC, 32'h0);

        // Redirect while a request is outstanding
        drive(0, 1, 32'h100, 1, 0, 0);
        #1 check("rd_req_v", 32'(ic_req_valid), 0);
        @(negedge clk);
        check("rd_ifid_v", 32'(if_id_valid), 0);
        drive(0, 0, 0, 1, 1, 32'hDEAD);
        #1 check("rd_req_v2", 32'(ic_req_valid), 1);
        check("rd_addr", ic_req_addr, 32'h100);
        @(negedge clk);
        check("stale_drop", 32'(if_id_valid), 0);
        check("stale_instr", if_id_instr, 32'h0);
        drive(0, 0, 0, 1, 1, 32'h55);
        @(negedge clk);
        check_ifid("rd_100", 1, 32'h100, 32'h55);

        // Redirect and stall together while a response is buffered
        drive(1, 0, 0, 1, 1, 32'h66);
        @(negedge clk);
        check_ifid("rs_hold", 1, 32'h100, 32'h55);
        drive(1, 1, 32'h200, 1, 0, 0);
        @(negedge clk);
        check("rs_flush_v", 32'(if_id_valid), 0);
        drive(0, 0, 0, 1, 0, 0);
        #1 check("rs_req_v", 32'(ic_req_valid), 1);
        check("rs_addr", ic_req_addr, 32'h200);
        @(negedge clk);
        check("rs_nobuf", 32'(if_id_valid), 0);
        drive(0, 0, 0, 1, 1, 32'h77);
        @(negedge clk);
        check_ifid("rs_200", 1, 32'h200, 32'h77);

        // Backpressure at the top of the address space, then wrap
        drive(0, 1, 32'hFFFF_FFFC, 0, 1, 32'hBAD);
        @(negedge clk);
        check("wr_flush_v", 32'(if_id_valid), 0);
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            #1 check("bp_req_v", 32'(ic_req_valid), 1);
            check("bp_addr", ic_req_addr, 32'hFFFF_FFFC);
            @(negedge clk);
        end
        drive(0, 0, 0, 1, 0, 0);
        #1 check("bp_acc_addr", ic_req_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        drive(0, 0, 0, 1, 1, 32'h88);
        #1 check("wrap_addr", ic_req_addr, 32'h0);
        @(negedge clk);
        check_ifid("wr_top", 1, 32'hFFFF_FFFC, 32'h88);

        // Asynchronous reset mid-operation; response during BOOT is ignored
        #2 rst_n = 1'b0;
        #1 check_ifid("mid_rst", 0, 32'h0, 32'h0);
        check("mid_rst_req", 32'(ic_req_valid), 0);
        drive(0, 0, 0, 1, 1, 32'h99);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("boot2_req_v", 32'(ic_req_valid), 0);
        @(negedge clk);
        drive(0, 0, 0, 1, 0, 0);
        #1 check("boot2_ign", 32'(if_id_valid), 0);
        check("boot2_req", 32'(ic_req_valid), 1);
        check("boot2_addr", ic_req_addr, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
